// File: rtl/addsub_monitor_if.sv
// Operand/result bundle shared by the add/subtract datapath and its monitor.
//
// Handshake: `en` qualifies dataa/datab/add_sub in the cycle it is high and
// there is no ready/backpressure; the monitor is passive and always accepts.
// `result` is the datapath's registered output, valid one edge after `en`.
interface addsub_monitor_if #(
    parameter int W = 8
);
    logic         en;
    logic [W-1:0] dataa;
    logic [W-1:0] datab;
    logic         add_sub;
    logic [W-1:0] result;

    // Stimulus / datapath side drives everything.
    modport master (
        output en,
        output dataa,
        output datab,
        output add_sub,
        output result
    );

    // Monitor side only observes.
    modport slave (
        input en,
        input dataa,
        input datab,
        input add_sub,
        input result
    );
endinterface

// File: rtl/addsub_monitor.sv
// Passive checker for the registered W-bit add/subtract datapath.
// Rebuilds the expected result one cycle behind the operands and compares it
// with the datapath's registered result. Reports a one-cycle error pulse, a
// sticky error flag, a sticky forbidden-state flag (1 + 1 -> 4), a wrapping
// check counter, a saturating error counter and a first-failure snapshot.
module addsub_monitor #(
    parameter int W            = 8,
    parameter int CNT_W        = 16,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic             clk,
    input  logic             rst,
    addsub_monitor_if.slave  bus,
    input  logic             clear,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic             forbidden_hit,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] err_count,
    output logic [W-1:0]     fail_a,
    output logic [W-1:0]     fail_b,
    output logic             fail_op,
    output logic [W-1:0]     fail_result,
    output logic [W-1:0]     fail_expected,
    output logic             halted,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;

    // Capture stage: mirrors what the datapath registered at the same edge.
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             op_q, op_d;
    logic             v_q, v_d;

    // Reporting state.
    logic             err_pulse_q, err_pulse_d;
    logic             err_sticky_q, err_sticky_d;
    logic             forbidden_q, forbidden_d;
    logic [CNT_W-1:0] check_cnt_q, check_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [W-1:0]     fail_a_q, fail_a_d;
    logic [W-1:0]     fail_b_q, fail_b_d;
    logic             fail_op_q, fail_op_d;
    logic [W-1:0]     fail_res_q, fail_res_d;
    logic [W-1:0]     fail_exp_q, fail_exp_d;

    // Comparison terms for the check pending in the capture stage.
    logic [W-1:0]     expected;
    logic             do_check;
    logic             mismatch;
    logic             forbidden;

    // Expected value and check qualification; carry/borrow are dropped.
    always_comb begin
        expected  = op_q ? (a_q + b_q) : (a_q - b_q);
        do_check  = v_q && (state_q == CHECK);
        mismatch  = (bus.result != expected);
        forbidden = (a_q == W'(1)) && (b_q == W'(1)) && (bus.result == W'(4));
    end

    // Next-state, capture and reporting logic; clear overrides any check.
    always_comb begin
        state_d      = state_q;
        a_d          = bus.dataa;
        b_d          = bus.datab;
        op_d         = bus.add_sub;
        v_d          = bus.en && (state_q != HALTED);
        err_pulse_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        forbidden_d  = forbidden_q;
        check_cnt_d  = check_cnt_q;
        err_cnt_d    = err_cnt_q;
        fail_a_d     = fail_a_q;
        fail_b_d     = fail_b_q;
        fail_op_d    = fail_op_q;
        fail_res_d   = fail_res_q;
        fail_exp_d   = fail_exp_q;

        // IDLE leaves on the edge that loads v_q, so the first check is
        // evaluated in the very next cycle (two edges after en).
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (do_check && mismatch && (STOP_ON_FAIL != 0)) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_check) begin
            check_cnt_d = check_cnt_q + CNT_W'(1);
            if (forbidden) begin
                forbidden_d = 1'b1;
            end
            if (mismatch) begin
                err_pulse_d  = 1'b1;
                err_sticky_d = 1'b1;
                if (err_cnt_q != {CNT_W{1'b1}}) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                // Snapshot only the first failure since reset/clear.
                if (!err_sticky_q) begin
                    fail_a_d   = a_q;
                    fail_b_d   = b_q;
                    fail_op_d  = op_q;
                    fail_res_d = bus.result;
                    fail_exp_d = expected;
                end
            end
        end

        // Clear discards a coinciding check; the capture stage still loads.
        if (clear) begin
            state_d      = IDLE;
            err_pulse_d  = 1'b0;
            err_sticky_d = 1'b0;
            forbidden_d  = 1'b0;
            check_cnt_d  = '0;
            err_cnt_d    = '0;
            fail_a_d     = '0;
            fail_b_d     = '0;
            fail_op_d    = 1'b0;
            fail_res_d   = '0;
            fail_exp_d   = '0;
        end
    end

    // State register; synchronous reset wins over clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 1'b0;
            v_q          <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            forbidden_q  <= 1'b0;
            check_cnt_q  <= '0;
            err_cnt_q    <= '0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_op_q    <= 1'b0;
            fail_res_q   <= '0;
            fail_exp_q   <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            v_q          <= v_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            forbidden_q  <= forbidden_d;
            check_cnt_q  <= check_cnt_d;
            err_cnt_q    <= err_cnt_d;
            fail_a_q     <= fail_a_d;
            fail_b_q     <= fail_b_d;
            fail_op_q    <= fail_op_d;
            fail_res_q   <= fail_res_d;
            fail_exp_q   <= fail_exp_d;
        end
    end

    // Outputs are straight flop copies.
    always_comb begin
        err_pulse     = err_pulse_q;
        err_sticky    = err_sticky_q;
        forbidden_hit = forbidden_q;
        check_count   = check_cnt_q;
        err_count     = err_cnt_q;
        fail_a        = fail_a_q;
        fail_b        = fail_b_q;
        fail_op       = fail_op_q;
        fail_result   = fail_res_q;
        fail_expected = fail_exp_q;
        halted        = (state_q == HALTED);
        dbg_state     = state_q;
    end

endmodule

// File: doc/addsub_monitor.md
# addsub_monitor

Passive checker on the result side of the registered 8-bit add/subtract datapath. It samples the same operand and `add_sub` inputs as the datapath, builds the expected result one cycle behind, and compares it with the datapath's registered `result`. It reports per-check errors, a sticky error flag, saturating counters and a first-failure snapshot. It also flags the forbidden state "operands 1 and 1, result 4". It sits beside the datapath in simulation and formal harnesses and drives nothing back into it.

## Interface
- `W`, 8: operand/result width.
- `CNT_W`, 16: width of `check_count` and `err_count`.
- `STOP_ON_FAIL`, 0: if 1, the monitor halts checking after the first mismatch until `clear`.

Ports:
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: sample operands this cycle.
- `dataa`  in  W: operand A, same net the datapath samples.
- `datab`  in  W: operand B.
- `add_sub`  in  1: 1 = add, 0 = subtract.
- `result`  in  W: datapath registered result.
- `clear`  in  1: clears sticky flags, counters, snapshot and HALTED state.
- `err_pulse`  out  1: one-cycle mismatch indication.
- `err_sticky`  out  1: at least one mismatch since reset/clear.
- `forbidden_hit`  out  1: sticky; the forbidden state was seen.
- `check_count`  out  CNT_W: comparisons performed, wraps.
- `err_count`  out  CNT_W: mismatches, saturates at all-ones.
- `fail_a`, `fail_b`  out  W: operands of the first failing check.
- `fail_op`  out  1: `add_sub` of the first failing check.
- `fail_result`, `fail_expected`  out  W: observed and expected values of the first failure.
- `halted`  out  1: high in HALTED.

## Operation
- Capture stage at each edge: `a_q<=dataa`, `b_q<=datab`, `op_q<=add_sub`, `v_q<=en && state!=HALTED`.
- Expected value: `op_q ? a_q+b_q : a_q-b_q`, computed modulo 2^W. Carry and borrow are discarded.
- A check happens in any cycle with `v_q==1` and state CHECK. Mismatch means `result != expected`.
- FSM:
  - IDLE (reset state): goes to CHECK on the first edge where `v_q` is set, i.e. one cycle after the first `en`.
  - CHECK: performs checks. On a mismatch with `STOP_ON_FAIL==1`, goes to HALTED.
  - HALTED: no checks; `check_count` and `err_count` are frozen. `clear` returns the FSM to IDLE.
- On each check edge:
  - `check_count` increments.
  - On mismatch: `err_pulse` is 1 for the next cycle, `err_sticky` sets, and `err_count` increments (saturating).
  - On the first mismatch only (while `err_sticky==0`): load `fail_*`.
- Forbidden state: `a_q==1 && b_q==1 && result==4` during a check. This sets `forbidden_hit` and is also a mismatch, because the expected value is 2 or 0.
- `clear` at an edge: zeroes counters, sticky flags and `fail_*`, and forces IDLE. The capture registers still load that edge. A check coinciding with `clear` is discarded, and `clear` wins.
- `rst` overrides `clear`. Every output is reset to 0: `err_pulse`, `err_sticky`, `forbidden_hit`, both counts, all `fail_*`, and `halted`. Reset also sets `v_q=0` and state IDLE.

## Timing
- Edge E0: operands are presented with `en=1`. The datapath and the monitor both register them.
- Between E0 and E1: `result` (updated at E0) is compared combinationally against expected.
- Edge E1: `err_pulse`, the counters, the sticky flags and the snapshot update. The stimulus-to-`err_pulse` latency is therefore 2 edges.
- Back-to-back `en` gives one check per cycle, fully pipelined with no bubbles.
- Reset mid-stream: checks pending in `v_q` are dropped. The first check after reset needs a fresh `en`.
- `en` low: no check. The counters hold and `err_pulse` is 0 the following cycle.

## Test plan
- Add, no error: `dataa=3`, `datab=5`, `add_sub=1`, `en=1`, correct datapath -> `result=8` at E1, `check_count=1`, `err_pulse=0`.
- Wrap: add 200+100 gives expected 44; subtract 1-2 gives expected 255. With a correct datapath, no error over 2 checks.
- Injected fault: force `result=4` with `a=b=1`, add -> `err_pulse=1` for exactly 1 cycle, `err_sticky=1`, `forbidden_hit=1`, `err_count=1`, and snapshot `fail_a=1`, `fail_b=1`, `fail_op=1`, `fail_result=4`, `fail_expected=2`.
- First-failure hold: 3 consecutive faulty checks -> `err_count=3`, and the snapshot holds the first one.
- `STOP_ON_FAIL=1`: after 1 fault -> `halted=1` and counts frozen over 10 further `en` cycles. `clear` -> all outputs 0, IDLE; the next `en` resumes checking.
- Saturation with `CNT_W=4`: 20 faults -> `err_count=15`, `check_count=4` (20 mod 16). Assert `rst` mid-stream -> all outputs 0 on the next cycle.
